vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_fb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: display refresh reads take absolute priority over
// writer requests on one single-port memory, with frame sync and stall stats.
module vga_fb_arbiter #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned ADDR_W   = 19,
   parameter int unsigned DATA_W   = 16
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic              blank_n,
   input  logic              vs,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              wr_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we_n,
   output logic              mem_oe_n,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   output logic              frame_start,
   output logic [15:0]       stall_cnt,
   input  logic              stat_clr
);

   localparam int unsigned FB_SIZE = H_ACTIVE * V_ACTIVE;
   localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(FB_SIZE - 1);
   localparam logic [ADDR_W:0]   FB_LIMIT = (ADDR_W + 1)'(FB_SIZE);

   typedef enum logic [1:0] {IDLE, READ, WRITE, WGAP} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_we_n_q, mem_we_n_d;
   logic              mem_oe_n_q, mem_oe_n_d;
   logic              rd_dly_q, rd_dly_d;
   logic [DATA_W-1:0] pix_data_q, pix_data_d;
   logic              pix_valid_q, pix_valid_d;
   logic              wr_ack_q, wr_ack_d;
   logic              wr_err_q, wr_err_d;
   logic              vs_q, vs_d;
   logic              vs_seen_q, vs_seen_d;
   logic              frame_start_q, frame_start_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;
   logic              vs_fall;
   logic              wr_in_range;

   // The very first sample after reset has no valid predecessor, so it never counts as a fall.
   assign vs_fall     = vs_seen_q & vs_q & ~vs;
   assign wr_in_range = ({1'b0, wr_addr} < FB_LIMIT);

   always_comb begin
      state_d       = state_q;
      pix_addr_d    = pix_addr_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_we_n_d    = 1'b1;
      mem_oe_n_d    = 1'b1;
      rd_dly_d      = ~mem_oe_n_q;
      pix_data_d    = pix_data_q;
      pix_valid_d   = rd_dly_q;
      wr_ack_d      = 1'b0;
      wr_err_d      = 1'b0;
      vs_d          = vs;
      vs_seen_d     = 1'b1;
      frame_start_d = vs_fall;
      stall_cnt_d   = stall_cnt_q;

      if (blank_n) begin
         state_d = READ;
      end else if (state_q == WRITE) begin
         state_d = WGAP;
      end else if (wr_req && (state_q != WGAP)) begin
         state_d = WRITE;
      end else begin
         state_d = IDLE;
      end

      case (state_q)
         READ: begin
            mem_oe_n_d = 1'b0;
            mem_addr_d = pix_addr_q;
            pix_addr_d = (pix_addr_q == PIX_LAST) ? '0 : pix_addr_q + ADDR_W'(1);
         end
         WRITE: begin
            wr_ack_d = 1'b1;
            wr_err_d = ~wr_in_range;
            if (wr_in_range) begin
               mem_we_n_d  = 1'b0;
               mem_addr_d  = wr_addr;
               mem_wdata_d = wr_data;
            end
         end
         default: ;
      endcase

      // Read data arrives one cycle after the strobe; capture it on the following edge.
      if (rd_dly_q) begin
         pix_data_d = mem_rdata;
      end

      if (vs_fall) begin
         pix_addr_d = '0;
      end

      if (stat_clr) begin
         stall_cnt_d = '0;
      end else if (wr_req && (state_q != WRITE) && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         pix_addr_q    <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_we_n_q    <= 1'b1;
         mem_oe_n_q    <= 1'b1;
         rd_dly_q      <= 1'b0;
         pix_data_q    <= '0;
         pix_valid_q   <= 1'b0;
         wr_ack_q      <= 1'b0;
         wr_err_q      <= 1'b0;
         vs_q          <= 1'b1;
         vs_seen_q     <= 1'b0;
         frame_start_q <= 1'b0;
         stall_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         pix_addr_q    <= pix_addr_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_we_n_q    <= mem_we_n_d;
         mem_oe_n_q    <= mem_oe_n_d;
         rd_dly_q      <= rd_dly_d;
         pix_data_q    <= pix_data_d;
         pix_valid_q   <= pix_valid_d;
         wr_ack_q      <= wr_ack_d;
         wr_err_q      <= wr_err_d;
         vs_q          <= vs_d;
         vs_seen_q     <= vs_seen_d;
         frame_start_q <= frame_start_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign wr_ack      = wr_ack_q;
   assign wr_err      = wr_err_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_we_n    = mem_we_n_q;
   assign mem_oe_n    = mem_oe_n_q;
   assign pix_data    = pix_data_q;
   assign pix_valid   = pix_valid_q;
   assign frame_start = frame_start_q;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter on a small 16x4 frame: the stimulus side
// predicts reads, pixels, frame pulses and write acks; a negedge monitor checks them.
module tb_vga_fb_arbiter;
   localparam int unsigned H  = 16;
   localparam int unsigned V  = 4;
   localparam int unsigned AW = 8;
   localparam int unsigned DW = 16;
   localparam int unsigned FB = H * V;

   logic          vga_clk = 1'b0;
   logic          reset_n, blank_n, vs, wr_req, stat_clr;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack, wr_err, mem_we_n, mem_oe_n, pix_valid, frame_start;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata, pix_data;
   logic [15:0]   stall_cnt;

   always #5 vga_clk = ~vga_clk;

   vga_fb_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW)) dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .blank_n(blank_n), .vs(vs),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .wr_err(wr_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n), .mem_rdata(mem_rdata),
      .pix_data(pix_data), .pix_valid(pix_valid), .frame_start(frame_start),
      .stall_cnt(stall_cnt), .stat_clr(stat_clr));

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return (DW'(a) * 16'd37) ^ 16'hC3A5;
   endfunction

   // Memory returns a fixed pattern of the address, one cycle after the read strobe.
   always @(posedge vga_clk) if (!mem_oe_n) mem_rdata <= pat(mem_addr);

   typedef struct { int cyc; logic [AW-1:0] addr; } rd_t;
   typedef struct { int cyc; logic [DW-1:0] data; } px_t;
   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic err; } wr_t;

   rd_t rdq[$];
   px_t pxq[$];
   wr_t wrq[$];
   int  fsq[$];

   int checks = 0, errors = 0, cyc = 0;
   bit mon_en = 0;
   int m_pix = 0;
   bit m_pend = 0, m_vsprev = 1, m_vsseen = 0;
   logic [DW-1:0] last_pix = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: one call per clock edge, using the inputs held across that edge.
   task automatic step();
      @(posedge vga_clk);
      cyc++;
      if (!reset_n) begin
         m_pix = 0; m_pend = 0; m_vsprev = 1; m_vsseen = 0; last_pix = '0;
         rdq.delete(); pxq.delete(); wrq.delete(); fsq.delete();
      end else begin
         if (m_pend) begin
            rdq.push_back('{cyc, AW'(m_pix)});
            pxq.push_back('{cyc + 2, pat(AW'(m_pix))});
            m_pix = (m_pix + 1) % FB;
         end
         if (m_vsseen && m_vsprev && !vs) begin
            fsq.push_back(cyc);
            m_pix = 0;
         end
         m_pend = blank_n; m_vsprev = vs; m_vsseen = 1;
      end
      #1;
   endtask

   task automatic issue_write(input int a, input logic [DW-1:0] d);
      wr_addr = AW'(a); wr_data = d; wr_req = 1'b1;
      wrq.push_back('{AW'(a), d, (a >= FB)});
   endtask

   task automatic wait_ack(input string name);
      for (int k = 0; k < 12 && !wr_ack; k++) step();
      chk(name, wr_ack, 1);
   endtask

   always @(negedge vga_clk) begin
      if (mon_en) begin
         bit e;
         e = (rdq.size() > 0) && (rdq[0].cyc == cyc);
         chk("rd_strobe", mem_oe_n, !e);
         if (e) begin
            chk("rd_addr", mem_addr, rdq[0].addr);
            rdq.pop_front();
         end
         e = (pxq.size() > 0) && (pxq[0].cyc == cyc);
         chk("pix_valid", pix_valid, e);
         if (e) begin
            chk("pix_data", pix_data, pxq[0].data);
            last_pix = pxq[0].data;
            pxq.pop_front();
         end else begin
            chk("pix_hold", pix_data, last_pix);
         end
         e = (fsq.size() > 0) && (fsq[0] == cyc);
         chk("frame_start", frame_start, e);
         if (e) fsq.pop_front();
         if (wr_ack) begin
            if (wrq.size() == 0) begin
               chk("extra_ack", wr_ack, 0);
            end else begin
               chk("wr_err", wr_err, wrq[0].err);
               chk("wr_we_n", mem_we_n, wrq[0].err);
               if (!wrq[0].err) begin
                  chk("wr_addr", mem_addr, wrq[0].addr);
                  chk("wr_data", mem_wdata, wrq[0].data);
               end
               wrq.pop_front();
            end
         end else begin
            chk("we_without_ack", mem_we_n, 1);
         end
      end
   end

   initial begin
      int burst, vs_low, wait_cnt, n;
      bit drop_next;
      burst = 0; vs_low = 0; wait_cnt = 0; drop_next = 0;
      reset_n = 0; blank_n = 0; vs = 0; wr_req = 0; stat_clr = 0;
      wr_addr = '0; wr_data = '0;
      repeat (3) step();
      chk("rst_we_n", mem_we_n, 1);
      chk("rst_oe_n", mem_oe_n, 1);
      chk("rst_addr", mem_addr, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_stall", stall_cnt, 0);
      reset_n = 1; mon_en = 1;
      // vs low on the first sample after reset must not pulse frame_start
      repeat (4) step();
      vs = 1;
      step();
      // continuous display: consecutive addresses with wrap at the frame end
      blank_n = 1;
      repeat (80) step();
      blank_n = 0;
      repeat (5) step();
      vs = 0; repeat (2) step();
      vs = 1; step();
      blank_n = 1; repeat (10) step();
      blank_n = 0; repeat (4) step();
      // write at 5, writer drops request one cycle late
      issue_write(5, 16'hABCD);
      wait_ack("ack_addr5");
      step(); wr_req = 0;
      repeat (6) step();
      issue_write(FB, 16'h1111);
      wait_ack("ack_oob");
      wr_req = 0; repeat (4) step();
      issue_write(FB - 1, 16'h2222);
      wait_ack("ack_last");
      wr_req = 0; repeat (4) step();
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (burst == 0) begin
            blank_n = ~blank_n;
            burst = blank_n ? $urandom_range(1, 40) : $urandom_range(1, 12);
         end
         burst--;
         if (vs_low > 0) begin
            vs = 0; vs_low--;
         end else begin
            vs = 1;
            if ($urandom_range(0, 150) == 0) vs_low = $urandom_range(1, 3);
         end
         stat_clr = ($urandom_range(0, 49) == 0);
         if (!wr_req && !drop_next && $urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 7) == 0) issue_write($urandom_range(FB, 255), DW'($urandom));
            else issue_write($urandom_range(0, FB - 1), DW'($urandom));
            wait_cnt = 0;
         end
         step();
         if (drop_next) begin
            wr_req = 0; drop_next = 0;
         end else if (wr_req && wr_ack) begin
            if ($urandom_range(0, 1) == 1) wr_req = 0;
            else drop_next = 1;
         end else if (wr_req) begin
            wait_cnt++;
            if (wait_cnt > 200) begin
               chk("wr_grant_timeout", wr_ack, 1);
               wr_req = 0; wrq.delete();
            end
         end
      end
      if (drop_next) wr_req = 0;
      blank_n = 0; vs = 1; stat_clr = 0;
      if (wr_req) begin
         wait_ack("drain_ack");
         wr_req = 0;
      end
      repeat (10) step();
      // writer stalled behind 100 display cycles, then granted after blanking
      blank_n = 1; repeat (3) step();
      stat_clr = 1; issue_write(9, 16'h1234);
      step();
      chk("stall_clr_prio", stall_cnt, 0);
      stat_clr = 0;
      repeat (100) step();
      chk("stall_100", stall_cnt, 100);
      chk("no_ack_in_display", wr_ack, 0);
      blank_n = 0; n = 0;
      while (!wr_ack && n < 6) begin step(); n++; end
      chk("grant_latency", n, 2);
      wr_req = 0;
      repeat (6) step();
      chk("rdq_empty", rdq.size(), 0);
      chk("pxq_empty", pxq.size(), 0);
      chk("wrq_empty", wrq.size(), 0);
      chk("fsq_empty", fsq.size(), 0);
      // reset asserted while a write strobe is on the bus
      mon_en = 0;
      wr_addr = AW'(7); wr_data = 16'h7777; wr_req = 1;
      for (int k = 0; k < 12 && mem_we_n; k++) step();
      chk("pre_rst_we", mem_we_n, 0);
      reset_n = 0;
      #1;
      chk("rst_mid_we_n", mem_we_n, 1);
      chk("rst_mid_ack", wr_ack, 0);
      chk("rst_mid_stall", stall_cnt, 0);
      chk("rst_mid_addr", mem_addr, 0);
      chk("rst_mid_wdata", mem_wdata, 0);
      wr_req = 0;
      repeat (2) step();
      reset_n = 1;
      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
